// File: rtl/sparse_stream_unpacker_if.sv
// AXI-Stream style bundle: full handshake with last, or valid-only realtime.
interface Axis_If #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport Master_Full     (output data, valid, last, input ready);
  modport Slave_Full      (input data, valid, last, output ready);
  modport Master_Realtime (output data, valid);
  modport Slave_Realtime  (input data, valid);
endinterface

// File: rtl/sparse_stream_unpacker.sv
// Splits the packed readout stream (timestamp segment, then sample segment ending in last)
// back into a timestamp stream and a sample stream at their native widths.
module sparse_stream_unpacker #(
  parameter int unsigned AXI_MM_WIDTH     = 128,
  parameter int unsigned TIMESTAMP_WIDTH  = 64,
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned PARALLEL_SAMPLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  Axis_If.Slave_Full         data_in,
  Axis_If.Slave_Realtime     config_in,
  Axis_If.Master_Full        timestamps_out,
  Axis_If.Master_Full        samples_out,
  output logic               framing_error
);

  localparam int unsigned BeatWidth = SAMPLE_WIDTH * PARALLEL_SAMPLES;
  localparam int unsigned TsLanes   = AXI_MM_WIDTH / TIMESTAMP_WIDTH;
  localparam int unsigned DLanes    = AXI_MM_WIDTH / BeatWidth;
  localparam int unsigned MaxLanes  = (TsLanes > DLanes) ? TsLanes : DLanes;
  localparam int unsigned LaneW     = (MaxLanes > 1) ? $clog2(MaxLanes) : 1;

  typedef enum logic [1:0] {StIdle, StTstamp, StData} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             rem_q, rem_d;
  logic [LaneW-1:0]        lane_q, lane_d;
  logic [AXI_MM_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic                    hold_last_q, hold_last_d;
  logic                    framing_error_q, framing_error_d;

  logic                    ts_valid, ts_last, smp_valid, smp_last, in_ready;
  logic                    ts_hs, smp_hs, ts_drain, smp_drain, in_hs;
  logic [AXI_MM_WIDTH-1:0] ts_shift, smp_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rem_q           <= '0;
      lane_q          <= '0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      hold_last_q     <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      lane_q          <= lane_d;
      hold_q          <= hold_d;
      hold_valid_q    <= hold_valid_d;
      hold_last_q     <= hold_last_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign ts_hs  = ts_valid & timestamps_out.ready;
  assign smp_hs = smp_valid & samples_out.ready;
  // A timestamp word is finished either on its top lane or on the final timestamp (padding).
  assign ts_drain  = ts_hs & ((lane_q == LaneW'(TsLanes - 1)) | (rem_q == 32'd1));
  assign smp_drain = smp_hs & (lane_q == LaneW'(DLanes - 1));
  assign in_hs     = data_in.valid & in_ready;

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    lane_d          = lane_q;
    hold_d          = hold_q;
    hold_valid_d    = hold_valid_q;
    hold_last_d     = hold_last_q;
    framing_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (config_in.valid) begin
          rem_d        = config_in.data;
          lane_d       = '0;
          hold_valid_d = 1'b0;
          state_d      = (config_in.data == 32'd0) ? StData : StTstamp;
        end
      end
      StTstamp: begin
        if (ts_hs) begin
          lane_d = lane_q + 1'b1;
          rem_d  = rem_q - 32'd1;
        end
        if (ts_drain) begin
          lane_d       = '0;
          hold_valid_d = 1'b0;
          // A word carrying last ends the frame before any sample segment.
          if (hold_last_q) begin
            framing_error_d = 1'b1;
            state_d         = StIdle;
          end else if (rem_q == 32'd1) begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (smp_hs) lane_d = lane_q + 1'b1;
        if (smp_drain) begin
          lane_d       = '0;
          hold_valid_d = 1'b0;
          if (hold_last_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (in_hs) begin
      hold_d       = data_in.data;
      hold_valid_d = 1'b1;
      hold_last_d  = data_in.last;
      lane_d       = '0;
    end
  end

  always_comb begin
    ts_valid  = 1'b0;
    ts_last   = 1'b0;
    smp_valid = 1'b0;
    smp_last  = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      StTstamp: begin
        ts_valid = hold_valid_q;
        ts_last  = hold_valid_q & (rem_q == 32'd1);
        in_ready = ~hold_valid_q | (ts_drain & ~hold_last_q);
      end
      StData: begin
        smp_valid = hold_valid_q;
        smp_last  = hold_valid_q & hold_last_q & (lane_q == LaneW'(DLanes - 1));
        in_ready  = ~hold_valid_q | (smp_drain & ~hold_last_q);
      end
      default: ;
    endcase
  end

  assign ts_shift  = hold_q >> (TIMESTAMP_WIDTH * 32'(lane_q));
  assign smp_shift = hold_q >> (BeatWidth * 32'(lane_q));

  assign data_in.ready        = in_ready;
  assign timestamps_out.valid = ts_valid;
  assign timestamps_out.last  = ts_last;
  assign timestamps_out.data  = ts_shift[TIMESTAMP_WIDTH-1:0];
  assign samples_out.valid    = smp_valid;
  assign samples_out.last     = smp_last;
  assign samples_out.data     = smp_shift[BeatWidth-1:0];
  assign framing_error        = framing_error_q;

endmodule

// File: tb/tb_sparse_stream_unpacker.sv
// Scoreboard bench for sparse_stream_unpacker: drivers push expected beats, monitors pop and compare.
module tb_sparse_stream_unpacker;
  localparam int unsigned AW = 128;
  localparam int unsigned TW = 64;
  localparam int unsigned SW = 16;

  logic clk = 1'b0;
  logic reset;
  logic framing_error;
  always #5 clk = ~clk;

  Axis_If #(.WIDTH(AW)) data_if ();
  Axis_If #(.WIDTH(32)) cfg_if ();
  Axis_If #(.WIDTH(TW)) ts_if ();
  Axis_If #(.WIDTH(SW)) smp_if ();

  sparse_stream_unpacker #(
    .AXI_MM_WIDTH    (AW),
    .TIMESTAMP_WIDTH (TW),
    .SAMPLE_WIDTH    (SW),
    .PARALLEL_SAMPLES(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_if),
    .config_in     (cfg_if),
    .timestamps_out(ts_if),
    .samples_out   (smp_if),
    .framing_error (framing_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW:0] ts_q  [$];
  logic [SW:0] smp_q [$];
  int ts_mode = 0, smp_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit gap_mode = 1'b0;
  int ts_seen = 0, fe_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [TW-1:0] tsv(input int f, input int i);
    return {16'hC0DE, 16'(f), 16'h0000, 16'(i)};
  endfunction

  function automatic logic [SW-1:0] smv(input int f, input int i);
    return {8'(f), 8'(i)};
  endfunction

  initial begin
    ts_if.ready  = 1'b0;
    smp_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ts_if.ready  = (ts_mode == 0) ? 1'b1 : (ts_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      smp_if.ready = (smp_mode == 0) ? 1'b1 : (smp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: samples at the falling edge, between the drivers' post-edge updates.
  initial begin
    logic [TW:0] tprev, texp;
    logic [SW:0] sprev, sexp;
    bit tstall = 1'b0, sstall = 1'b0, fe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        tstall = 1'b0; sstall = 1'b0; fe_prev = 1'b0;
        continue;
      end
      if (ts_if.valid) ts_seen++;
      if (ts_if.valid && smp_if.valid) fail_now("both_streams_valid");
      if (tstall && ts_if.valid) check("ts_stable", {ts_if.last, ts_if.data}, tprev);
      if (sstall && smp_if.valid) check("smp_stable", {smp_if.last, smp_if.data}, sprev);
      if (ts_if.valid && ts_if.ready) begin
        if (ts_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ts_unexpected: got %h required none", {ts_if.last, ts_if.data});
        end else begin
          texp = ts_q.pop_front();
          check("ts_beat", {ts_if.last, ts_if.data}, texp);
        end
      end
      if (smp_if.valid && smp_if.ready) begin
        if (smp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL smp_unexpected: got %h required none", {smp_if.last, smp_if.data});
        end else begin
          sexp = smp_q.pop_front();
          check("smp_beat", {smp_if.last, smp_if.data}, sexp);
        end
      end
      tstall = ts_if.valid && !ts_if.ready;
      tprev  = {ts_if.last, ts_if.data};
      sstall = smp_if.valid && !smp_if.ready;
      sprev  = {smp_if.last, smp_if.data};
      if (framing_error) begin
        fe_cnt++;
        if (fe_prev) fail_now("framing_error_wider_than_one_cycle");
      end
      fe_prev = framing_error;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // All driver tasks start and end at posedge+1.
  task automatic send_cfg(input logic [31:0] n);
    cfg_if.data  = n;
    cfg_if.valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] w, input bit last);
    int t;
    if (gap_mode) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    data_if.data  = w;
    data_if.last  = last;
    data_if.valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (data_if.ready) break;
      t++;
      if (t > 1000) begin
        fail_now("data_in_ready_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    data_if.valid = 1'b0;
    data_if.last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((ts_q.size() != 0 || smp_q.size() != 0) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("queues_drained", 128'(ts_q.size() + smp_q.size()), 128'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ts_word(input int f, input int w, input int n_ts, input bit trunc);
    logic [AW-1:0] word;
    word = {tsv(f, 2 * w + 1), tsv(f, 2 * w)};
    for (int l = 0; l < 2; l++) begin
      if (2 * w + l < n_ts) ts_q.push_back({(!trunc && (2 * w + l == n_ts - 1)), tsv(f, 2 * w + l)});
    end
    send_word(word, 1'b0);
  endtask

  task automatic push_data_word(input int f, input int w, input bit last);
    logic [AW-1:0] word;
    for (int l = 0; l < 8; l++) begin
      word[16*l +: 16] = smv(f, 8 * w + l);
      smp_q.push_back({(last && l == 7), smv(f, 8 * w + l)});
    end
    send_word(word, last);
  endtask

  task automatic run_frame(input int f, input int n_ts, input int n_tw, input int n_dw,
                           input bit trunc);
    logic [AW-1:0] word;
    send_cfg(32'(n_ts));
    for (int w = 0; w < n_tw; w++) begin
      if (trunc && w == n_tw - 1) begin
        word = {tsv(f, 2 * w + 1), tsv(f, 2 * w)};
        ts_q.push_back({1'b0, tsv(f, 2 * w)});
        ts_q.push_back({1'b0, tsv(f, 2 * w + 1)});
        send_word(word, 1'b1);
      end else begin
        push_ts_word(f, w, n_ts, trunc);
      end
    end
    for (int w = 0; w < n_dw; w++) push_data_word(f, w, w == n_dw - 1);
    wait_drain();
  endtask

  initial begin
    int s, f0;
    reset         = 1'b1;
    data_if.valid = 1'b0;
    data_if.last  = 1'b0;
    data_if.data  = '0;
    cfg_if.valid  = 1'b0;
    cfg_if.last   = 1'b0;
    cfg_if.ready  = 1'b0;
    cfg_if.data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_in_ready", 128'(data_if.ready), 128'd0);
    check("reset_ts_valid", 128'(ts_if.valid), 128'd0);
    check("reset_ts_last", 128'(ts_if.last), 128'd0);
    check("reset_smp_valid", 128'(smp_if.valid), 128'd0);
    check("reset_smp_last", 128'(smp_if.last), 128'd0);
    check("reset_framing_error", 128'(framing_error), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Aligned frame: 4 timestamps, 3 sample words.
    run_frame(1, 4, 2, 3, 1'b0);
    // Padded: upper lane of the second timestamp word must be dropped.
    run_frame(2, 3, 2, 2, 1'b0);
    // No timestamps at all.
    s = ts_seen;
    run_frame(3, 0, 0, 1, 1'b0);
    check("nts0_no_ts_valid", 128'(ts_seen - s), 128'd0);

    // Random backpressure and input gaps.
    ts_mode = 1; smp_mode = 1; gap_mode = 1'b1;
    run_frame(4, 4, 2, 3, 1'b0);
    run_frame(5, 5, 3, 2, 1'b0);
    run_frame(6, 1, 1, 1, 1'b0);
    ts_mode = 0; smp_mode = 0; gap_mode = 1'b0;
    check("no_spurious_framing_error", 128'(fe_cnt), 128'd0);

    // Truncated frame: last arrives on the second timestamp word.
    f0 = fe_cnt;
    run_frame(7, 8, 2, 0, 1'b1);
    check("truncated_fe_pulses", 128'(fe_cnt - f0), 128'd1);
    run_frame(8, 2, 1, 1, 1'b0);

    // Reset mid-DATA with a stalled sample word in the holding register.
    smp_mode = 2;
    send_cfg(32'd0);
    send_word({8{16'hDEAD}}, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stalled_in_data_smp_valid", 128'(smp_if.valid), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_smp_valid", 128'(smp_if.valid), 128'd0);
    check("post_reset_ts_valid", 128'(ts_if.valid), 128'd0);
    check("post_reset_data_in_ready", 128'(data_if.ready), 128'd0);
    @(posedge clk);
    #1;
    smp_mode = 0;

    // Fresh frame; a config pulse during DATA must be ignored.
    f0 = fe_cnt;
    send_cfg(32'd2);
    push_ts_word(9, 0, 2, 1'b0);
    push_data_word(9, 0, 1'b0);
    send_cfg(32'd5);
    push_data_word(9, 1, 1'b1);
    wait_drain();
    run_frame(10, 2, 1, 1, 1'b0);
    check("post_reset_no_framing_error", 128'(fe_cnt - f0), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
